// File: rtl/dma_bus_arbiter.sv
// Shared memory bus arbiter for CPU, HDMA/GDMA and OAM DMA.
// Each DMA byte becomes a read-capture-write sequence; the CPU passes through when idle.
module dma_bus_arbiter #(
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter logic [7:0]  OAM_LEN  = 8'd160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdma_rd,
  input  logic        hdma_active,
  input  logic [15:0] hdma_src,
  input  logic [15:0] hdma_dst,
  input  logic        odma_req,
  input  logic [15:0] odma_src,
  input  logic [7:0]  odma_idx,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  grant,
  output logic        hdma_ack,
  output logic        odma_ack
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;
  typedef enum logic [1:0] {SEL_CPU = 2'd0, SEL_HDMA = 2'd1, SEL_OAM = 2'd2} sel_t;

  state_t      state;
  sel_t        src_sel;
  logic [15:0] src_q, dst_q, hlast_q, olast_q;
  logic [7:0]  data_q;
  logic        hv_q, ov_q;

  logic hdma_pend, odma_pend, dma_start, oam_hit, oam_blk, cpu_acc;

  // A byte is new when its source address differs from the last one serviced.
  assign hdma_pend = hdma_rd  && (!hv_q || (hdma_src != hlast_q));
  assign odma_pend = odma_req && (!ov_q || (odma_src != olast_q));
  assign dma_start = (state == IDLE) && (hdma_pend || odma_pend);

  assign oam_hit = ({1'b0, cpu_addr} >= {1'b0, OAM_BASE}) &&
                   ({1'b0, cpu_addr} <  ({1'b0, OAM_BASE} + {9'd0, OAM_LEN}));
  assign oam_blk = odma_req && oam_hit;
  assign cpu_acc = (cpu_rd || cpu_wr) && !oam_blk;

  assign cpu_stall = hdma_active || (cpu_acc && ((state != IDLE) || dma_start));
  assign cpu_rdata = (oam_blk && cpu_rd) ? 8'hFF : mem_rdata;
  assign grant     = (state == IDLE) ? 2'd0 : src_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    mem_addr  = cpu_addr;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = cpu_wdata;
    case (state)
      IDLE: if (!dma_start) begin
        mem_rd = cpu_rd;
        mem_wr = cpu_wr && !oam_blk;
      end
      RD: begin
        mem_addr = src_q;
        mem_rd   = 1'b1;
      end
      CAP: mem_addr = src_q;
      WR: begin
        mem_addr  = dst_q;
        mem_wr    = 1'b1;
        mem_wdata = data_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      src_sel  <= SEL_CPU;
      src_q    <= 16'h0000;
      dst_q    <= 16'h0000;
      data_q   <= 8'h00;
      hlast_q  <= 16'h0000;
      olast_q  <= 16'h0000;
      hv_q     <= 1'b0;
      ov_q     <= 1'b0;
      hdma_ack <= 1'b0;
      odma_ack <= 1'b0;
    end else begin
      hdma_ack <= 1'b0;
      odma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (hdma_pend) begin
            src_q   <= hdma_src;
            dst_q   <= hdma_dst;
            src_sel <= SEL_HDMA;
            state   <= RD;
          end else if (odma_pend) begin
            src_q   <= odma_src;
            dst_q   <= OAM_BASE + {8'h00, odma_idx};
            src_sel <= SEL_OAM;
            state   <= RD;
          end
        end
        RD: state <= CAP;
        CAP: begin
          data_q <= mem_rdata;
          state  <= WR;
          // Ack is registered so it is high exactly during the WR cycle.
          if (src_sel == SEL_HDMA) hdma_ack <= 1'b1;
          else                     odma_ack <= 1'b1;
        end
        WR: begin
          state <= IDLE;
          if (src_sel == SEL_HDMA) begin
            hlast_q <= src_q;
            hv_q    <= 1'b1;
          end else begin
            olast_q <= src_q;
            ov_q    <= 1'b1;
          end
        end
      endcase
      // A dropped request forgets its last address so the same byte can be re-sent.
      if (!hdma_rd)  hv_q <= 1'b0;
      if (!odma_req) ov_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter with a registered memory model.
`timescale 1ns/1ps
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hdma_rd = 1'b0, hdma_active = 1'b0;
  logic [15:0] hdma_src = 16'h0, hdma_dst = 16'h0;
  logic        odma_req = 1'b0;
  logic [15:0] odma_src = 16'h0;
  logic [7:0]  odma_idx = 8'h0;
  logic [15:0] cpu_addr = 16'h0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  grant;
  logic        hdma_ack, odma_ack;

  int n_checks = 0;
  int n_fail = 0;
  int hack_cnt = 0;
  int oack_cnt = 0;
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  dma_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .hdma_rd(hdma_rd), .hdma_active(hdma_active), .hdma_src(hdma_src), .hdma_dst(hdma_dst),
    .odma_req(odma_req), .odma_src(odma_src), .odma_idx(odma_idx),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .hdma_ack(hdma_ack), .odma_ack(odma_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // Memory returns data the cycle after a read strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_val(mem_addr);

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (hdma_ack) hack_cnt++;
    if (odma_ack) oack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", mem_rd, mem_wr); end
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    n_checks++; if (hdma_ack !== 1'b0 || odma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got %b%b expected 00", hdma_ack, odma_ack); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo: got %b expected 0", cpu_stall); end
    hdma_active = 1'b1; #1;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_hi: got %b expected 1", cpu_stall); end
    hdma_active = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int base_a, got;
    base_a = hack_cnt;
    hdma_src = 16'h1234; hdma_dst = 16'h8010; hdma_rd = 1'b1;
    #1;
    n_checks++; if (grant !== 2'd0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL lat_T0: grant=%0d rd=%b expected 0 0", grant, mem_rd); end
    tick();
    n_checks++; if (grant !== 2'd1 || mem_rd !== 1'b1 || mem_addr !== 16'h1234) begin n_fail++; $display("FAIL lat_RD: grant=%0d rd=%b addr=%h expected 1 1 1234", grant, mem_rd, mem_addr); end
    tick();
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h1234) begin n_fail++; $display("FAIL lat_CAP: rd=%b wr=%b addr=%h expected 0 0 1234", mem_rd, mem_wr, mem_addr); end
    tick();
    n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h8010 || hdma_ack !== 1'b1) begin n_fail++; $display("FAIL lat_WR: wr=%b addr=%h ack=%b expected 1 8010 1", mem_wr, mem_addr, hdma_ack); end
    n_checks++; if (mem_wdata !== mem_val(16'h1234)) begin n_fail++; $display("FAIL lat_wdata: got %h expected %h", mem_wdata, mem_val(16'h1234)); end
    tick();
    n_checks++; if (grant !== 2'd0 || hdma_ack !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL lat_T4: grant=%0d ack=%b wr=%b expected 0 0 0", grant, hdma_ack, mem_wr); end
    repeat (6) tick();
    n_checks++; if (hack_cnt - base_a !== 1) begin n_fail++; $display("FAIL same_src_held: acks=%0d expected 1", hack_cnt - base_a); end
    hdma_rd = 1'b0; tick();
    hdma_rd = 1'b1; got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      tick();
      if (hdma_ack === 1'b1) got = 1;
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL retransfer: ack seen=%0d expected 1", got); end
    hdma_rd = 1'b0;
    repeat (2) tick();
    n_checks++; if (hack_cnt - base_a !== 2) begin n_fail++; $display("FAIL retransfer_cnt: acks=%0d expected 2", hack_cnt - base_a); end
  endtask

  task automatic test_gdma();
    int base_w, base_a, bytes, stall_bad;
    base_w = wr_addr_q.size(); base_a = hack_cnt; bytes = 0; stall_bad = 0;
    hdma_src = 16'h2040; hdma_dst = 16'h8200; hdma_rd = 1'b1; hdma_active = 1'b1;
    // Engine model: advance addresses in the WR cycle of each byte.
    for (int c = 0; c < 400 && bytes < 32; c++) begin
      tick();
      if (cpu_stall !== 1'b1) stall_bad++;
      if (hdma_ack === 1'b1) begin bytes++; hdma_src++; hdma_dst++; end
    end
    hdma_rd = 1'b0; hdma_active = 1'b0;
    repeat (3) tick();
    n_checks++; if (hack_cnt - base_a !== 32) begin n_fail++; $display("FAIL gdma_acks: got %0d expected 32", hack_cnt - base_a); end
    n_checks++; if (wr_addr_q.size() - base_w !== 32) begin n_fail++; $display("FAIL gdma_writes: got %0d expected 32", wr_addr_q.size() - base_w); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL gdma_stall: %0d cycles unstalled expected 0", stall_bad); end
    for (int i = 0; i < 32; i++) begin
      if (base_w + i < wr_addr_q.size()) begin
        n_checks++;
        if (wr_addr_q[base_w+i] !== 16'h8200 + 16'(i) || wr_data_q[base_w+i] !== mem_val(16'h2040 + 16'(i))) begin
          n_fail++;
          $display("FAIL gdma_byte%0d: addr=%h data=%h expected %h %h", i, wr_addr_q[base_w+i], wr_data_q[base_w+i], 16'h8200 + 16'(i), mem_val(16'h2040 + 16'(i)));
        end
      end
    end
  endtask

  task automatic test_oam();
    int base_w, base_a, got, bad, fe20;
    base_w = wr_addr_q.size(); base_a = oack_cnt; bad = 0; fe20 = 0;
    odma_req = 1'b1;
    for (int i = 0; i < 160; i++) begin
      odma_src = 16'hC100 + 16'(i); odma_idx = 8'(i);
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        tick();
        if (odma_ack === 1'b1) got = 1;
      end
      if (got == 0) begin
        n_checks++; n_fail++;
        $display("FAIL oam_timeout: byte %0d no ack expected ack", i);
        break;
      end
      tick();
      if (i == 16) begin
        cpu_rd = 1'b1; cpu_addr = 16'hFE10; #1;
        n_checks++; if (cpu_rdata !== 8'hFF || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL oam_block_rd: data=%h stall=%b expected ff 0", cpu_rdata, cpu_stall); end
      end
      if (i == 40) begin
        cpu_rd = 1'b1; cpu_addr = 16'hFF80; #1;
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFF80 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL hram_rd_bus: rd=%b addr=%h stall=%b expected 1 ff80 0", mem_rd, mem_addr, cpu_stall); end
      end
      if (i == 80) begin
        cpu_wr = 1'b1; cpu_addr = 16'hFE20; cpu_wdata = 8'h77; #1;
        n_checks++; if (mem_wr !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL oam_block_wr: wr=%b stall=%b expected 0 0", mem_wr, cpu_stall); end
      end
      tick();
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
      if (i == 40) begin
        #1;
        n_checks++; if (cpu_rdata !== mem_val(16'hFF80)) begin n_fail++; $display("FAIL hram_rd_data: got %h expected %h", cpu_rdata, mem_val(16'hFF80)); end
      end
    end
    odma_req = 1'b0;
    repeat (3) tick();
    n_checks++; if (oack_cnt - base_a !== 160) begin n_fail++; $display("FAIL oam_acks: got %0d expected 160", oack_cnt - base_a); end
    n_checks++; if (wr_addr_q.size() - base_w !== 160) begin n_fail++; $display("FAIL oam_writes: got %0d expected 160", wr_addr_q.size() - base_w); end
    for (int i = base_w; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] == 16'hFE20) fe20++;
      if (wr_addr_q[i] !== 16'hFE00 + 16'(i - base_w) || wr_data_q[i] !== mem_val(16'hC100 + 16'(i - base_w))) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL oam_contents: %0d wrong bytes expected 0", bad); end
    n_checks++; if (fe20 !== 1) begin n_fail++; $display("FAIL oam_fe20: %0d writes expected 1", fe20); end
  endtask

  task automatic test_simultaneous();
    int base_h, base_o;
    logic [1:0] exp_g [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    base_h = hack_cnt; base_o = oack_cnt;
    hdma_src = 16'h3000; hdma_dst = 16'h8000; hdma_rd = 1'b1;
    odma_src = 16'hC200; odma_idx = 8'd5; odma_req = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      n_checks++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL both_grant_c%0d: got %0d expected %0d", k, grant, exp_g[k]); end
      n_checks++; if (hdma_ack !== (k == 3) || odma_ack !== (k == 7)) begin n_fail++; $display("FAIL both_ack_c%0d: got %b%b expected %b%b", k, hdma_ack, odma_ack, k == 3, k == 7); end
      if (k == 7) begin
        n_checks++; if (mem_addr !== 16'hFE05 || mem_wdata !== mem_val(16'hC200)) begin n_fail++; $display("FAIL both_oam_wr: addr=%h data=%h expected fe05 %h", mem_addr, mem_wdata, mem_val(16'hC200)); end
      end
      tick();
    end
    hdma_rd = 1'b0; odma_req = 1'b0;
    repeat (2) tick();
    n_checks++; if (hack_cnt - base_h !== 1 || oack_cnt - base_o !== 1) begin n_fail++; $display("FAIL both_once: h=%0d o=%0d expected 1 1", hack_cnt - base_h, oack_cnt - base_o); end
  endtask

  task automatic test_cpu_stall();
    cpu_wr = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'hA5;
    hdma_src = 16'h4000; hdma_dst = 16'h9000; hdma_rd = 1'b1;
    #1;
    n_checks++; if (cpu_stall !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL stall_start: stall=%b wr=%b expected 1 0", cpu_stall, mem_wr); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL stall_c%0d: got %b expected 1", k, cpu_stall); end
    end
    tick();
    n_checks++; if (cpu_stall !== 1'b0 || mem_wr !== 1'b1 || mem_addr !== 16'hC000 || mem_wdata !== 8'hA5) begin
      n_fail++; $display("FAIL stall_release: stall=%b wr=%b addr=%h data=%h expected 0 1 c000 a5", cpu_stall, mem_wr, mem_addr, mem_wdata);
    end
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    tick();
  endtask

  task automatic test_reset_mid();
    int base_a, base_w;
    hdma_src = 16'h5000; hdma_dst = 16'h9100; hdma_rd = 1'b1;
    tick(); tick();
    base_a = hack_cnt; base_w = wr_addr_q.size();
    n_checks++; if (grant !== 2'd1 || mem_rd !== 1'b0 || mem_addr !== 16'h5000) begin n_fail++; $display("FAIL rst_in_cap: grant=%0d rd=%b addr=%h expected 1 0 5000", grant, mem_rd, mem_addr); end
    reset = 1'b1;
    tick();
    n_checks++; if (mem_wr !== 1'b0 || grant !== 2'd0 || hdma_ack !== 1'b0) begin n_fail++; $display("FAIL rst_next: wr=%b grant=%0d ack=%b expected 0 0 0", mem_wr, grant, hdma_ack); end
    hdma_rd = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    n_checks++; if (hack_cnt - base_a !== 0 || wr_addr_q.size() - base_w !== 0) begin n_fail++; $display("FAIL rst_no_write: acks=%0d writes=%0d expected 0 0", hack_cnt - base_a, wr_addr_q.size() - base_w); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_gdma();
    test_oam();
    test_simultaneous();
    test_cpu_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
